// File: rtl/main_memory_arbiter_pkg.sv
// Shared encodings and default timeout sizing for the main-memory arbiter.
package main_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2,
    RECOVER  = 2'd3
  } stateT;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } ownerT;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int DEFAULT_TIMEOUT_WIDTH  = 5;

endpackage

// File: rtl/main_memory_arbiter_timer.sv
// ACK wait counter: held at zero while cleared, counts while enabled,
// flags the last permitted cycle so the FSM can abandon the access.
module main_memory_arbiter_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing single-port main memory between instruction
// fetch (port 0) and load/store (port 1). Optional ACK timeout: MEM_ARB_TIMEOUT_EN.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH
) (
  input  logic                     MEM_ARB_CLOCK_50,
  input  logic                     MEM_ARB_RESET_InLow,
  input  logic                     MEM_ARB_REQ0_RD,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARB_REQ0_ADDRESS_InBUS,
  output logic                     MEM_ARB_REQ0_GNT,
  output logic                     MEM_ARB_REQ0_DONE,
  output logic                     MEM_ARB_REQ0_ERR,
  input  logic                     MEM_ARB_REQ1_RD,
  input  logic                     MEM_ARB_REQ1_WR,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARB_REQ1_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARB_REQ1_data_InBUS,
  output logic                     MEM_ARB_REQ1_GNT,
  output logic                     MEM_ARB_REQ1_DONE,
  output logic                     MEM_ARB_REQ1_ERR,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARB_data_OutBUS,
  output logic                     MEM_ARB_MEM_RD,
  output logic                     MEM_ARB_MEM_WR,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARB_MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARB_MEM_data_OutBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARB_MEM_data_InBUS,
  input  logic                     MEM_ARB_MEM_ACK
);

  stateT state;
  ownerT lastOwner;
  ownerT nextOwner;
  logic  anyReq;
  logic  grantWrite;
  logic  gnt0, gnt1, done0, done1;
  logic  memRd, memWr;
  logic [DATAWIDTH_BUS-1:0] memAddr, memData, dataOut;

  assign anyReq = MEM_ARB_REQ0_RD || MEM_ARB_REQ1_RD || MEM_ARB_REQ1_WR;

  // Contention goes to whichever port did not own the previous access.
  always_comb begin
    nextOwner = PORT1;
    if (MEM_ARB_REQ0_RD && (MEM_ARB_REQ1_RD || MEM_ARB_REQ1_WR)) begin
      nextOwner = (lastOwner == PORT0) ? PORT1 : PORT0;
    end else if (MEM_ARB_REQ0_RD) begin
      nextOwner = PORT0;
    end
  end

  assign grantWrite = (nextOwner == PORT1) && MEM_ARB_REQ1_WR;

`ifdef MEM_ARB_TIMEOUT_EN
  logic timerExpired;
  logic err0, err1;

  main_memory_arbiter_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) uTimer (
    .clk    (MEM_ARB_CLOCK_50),
    .rstN   (MEM_ARB_RESET_InLow),
    .clear  (state != ACCESS),
    .enable (state == ACCESS),
    .expired(timerExpired)
  );

  assign MEM_ARB_REQ0_ERR = err0;
  assign MEM_ARB_REQ1_ERR = err1;
`else
  assign MEM_ARB_REQ0_ERR = 1'b0;
  assign MEM_ARB_REQ1_ERR = 1'b0;
`endif

  always_ff @(posedge MEM_ARB_CLOCK_50 or negedge MEM_ARB_RESET_InLow) begin
    if (!MEM_ARB_RESET_InLow) begin
      state     <= IDLE;
      lastOwner <= PORT1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      memRd     <= 1'b0;
      memWr     <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
      dataOut   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err0      <= 1'b0;
      err1      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            lastOwner <= nextOwner;
            gnt0      <= (nextOwner == PORT0);
            gnt1      <= (nextOwner == PORT1);
            memRd     <= !grantWrite;
            memWr     <= grantWrite;
            memAddr   <= (nextOwner == PORT0) ? MEM_ARB_REQ0_ADDRESS_InBUS
                                              : MEM_ARB_REQ1_ADDRESS_InBUS;
            memData   <= MEM_ARB_REQ1_data_InBUS;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (MEM_ARB_MEM_ACK) begin
            if (memRd) dataOut <= MEM_ARB_MEM_data_InBUS;
            memRd <= 1'b0;
            memWr <= 1'b0;
            done0 <= gnt0;
            done1 <= gnt1;
            state <= COMPLETE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timerExpired) begin
            memRd <= 1'b0;
            memWr <= 1'b0;
            done0 <= gnt0;
            done1 <= gnt1;
            err0  <= gnt0;
            err1  <= gnt1;
            state <= COMPLETE;
          end
`endif
        end
        COMPLETE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          err0  <= 1'b0;
          err1  <= 1'b0;
`endif
          state <= MEM_ARB_MEM_ACK ? RECOVER : IDLE;
        end
        RECOVER: begin
          if (!MEM_ARB_MEM_ACK) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MEM_ARB_REQ0_GNT           = gnt0;
  assign MEM_ARB_REQ1_GNT           = gnt1;
  assign MEM_ARB_REQ0_DONE          = done0;
  assign MEM_ARB_REQ1_DONE          = done1;
  assign MEM_ARB_MEM_RD             = memRd;
  assign MEM_ARB_MEM_WR             = memWr;
  assign MEM_ARB_MEM_ADDRESS_OutBUS = memAddr;
  assign MEM_ARB_MEM_data_OutBUS    = memData;
  assign MEM_ARB_data_OutBUS        = dataOut;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Self-checking bench for main_memory_arbiter: vector table, corner-case
// sequences and randomized transactions against a transaction-level model.
module tb_main_memory_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req0Rd, req1Rd, req1Wr;
  logic [31:0] req0Addr, req1Addr, req1Data;
  logic        gnt0, done0, err0, gnt1, done1, err1;
  logic [31:0] dataOut, memAddr, memWData, memIn;
  logic        memRd, memWr, memAck;

  always #5 clk = ~clk;

  main_memory_arbiter #(
    .DATAWIDTH_BUS (32),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_WIDTH (5)
  ) dut (
    .MEM_ARB_CLOCK_50          (clk),
    .MEM_ARB_RESET_InLow       (rstN),
    .MEM_ARB_REQ0_RD           (req0Rd),
    .MEM_ARB_REQ0_ADDRESS_InBUS(req0Addr),
    .MEM_ARB_REQ0_GNT          (gnt0),
    .MEM_ARB_REQ0_DONE         (done0),
    .MEM_ARB_REQ0_ERR          (err0),
    .MEM_ARB_REQ1_RD           (req1Rd),
    .MEM_ARB_REQ1_WR           (req1Wr),
    .MEM_ARB_REQ1_ADDRESS_InBUS(req1Addr),
    .MEM_ARB_REQ1_data_InBUS   (req1Data),
    .MEM_ARB_REQ1_GNT          (gnt1),
    .MEM_ARB_REQ1_DONE         (done1),
    .MEM_ARB_REQ1_ERR          (err1),
    .MEM_ARB_data_OutBUS       (dataOut),
    .MEM_ARB_MEM_RD            (memRd),
    .MEM_ARB_MEM_WR            (memWr),
    .MEM_ARB_MEM_ADDRESS_OutBUS(memAddr),
    .MEM_ARB_MEM_data_OutBUS   (memWData),
    .MEM_ARB_MEM_data_InBUS    (memIn),
    .MEM_ARB_MEM_ACK           (memAck)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: last owner and last successfully read word.
  bit          refLast;
  logic [31:0] refDout;

  typedef struct {
    bit          r0, r1rd, r1wr;
    logic [31:0] a0, a1, wd, rdv;
    bit          eOwn, eWr;
    logic [31:0] eAddr, eDout;
  } vecT;

  vecT vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit predictOwner(input bit r0, input bit r1);
    if (r0 && r1) return !refLast;
    return r1;
  endfunction

  task automatic doTxn(input bit r0, input bit r1rd, input bit r1wr,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd, input logic [31:0] rdv,
                       input bit eOwn, input bit eWr,
                       input logic [31:0] eAddr, input logic [31:0] eDout,
                       input int lat, input int hold);
    logic [1:0] ownBits;
    ownBits = eOwn ? 2'b10 : 2'b01;
    req0Rd = r0; req1Rd = r1rd; req1Wr = r1wr;
    req0Addr = a0; req1Addr = a1; req1Data = wd;
    tick();
    check("grant", {30'd0, gnt1, gnt0}, {30'd0, ownBits});
    check("strobes", {30'd0, memWr, memRd}, {30'd0, eWr, !eWr});
    check("memAddr", memAddr, eAddr);
    if (eWr) check("memWData", memWData, wd);
    req0Rd = 1'b0; req1Rd = 1'b0; req1Wr = 1'b0;
    req0Addr = $urandom; req1Addr = $urandom; req1Data = $urandom;
    for (int i = 0; i < lat; i++) begin
      tick();
      check("strobeHeld", {31'd0, memRd | memWr}, 32'd1);
      check("noEarlyDone", {30'd0, done1, done0}, 32'd0);
    end
    memAck = 1'b1; memIn = rdv;
    tick();
    check("done", {30'd0, done1, done0}, {30'd0, ownBits});
    check("strobeDrop", {30'd0, memWr, memRd}, 32'd0);
    check("dataOut", dataOut, eDout);
    check("gntComplete", {30'd0, gnt1, gnt0}, {30'd0, ownBits});
    check("errOnAck", {30'd0, err1, err0}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("recoverNoDone", {30'd0, done1, done0}, 32'd0);
      check("recoverNoStrobe", {30'd0, memWr, memRd}, 32'd0);
    end
    memAck = 1'b0; memIn = $urandom;
    tick();
    check("idleGnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("idleDone", {30'd0, done1, done0}, 32'd0);
    refLast = eOwn;
    refDout = eDout;
  endtask

  initial begin
    rstN = 1'b0;
    req0Rd = 1'b0; req1Rd = 1'b0; req1Wr = 1'b0;
    req0Addr = '0; req1Addr = '0; req1Data = '0;
    memIn = '0; memAck = 1'b0;
    refLast = 1'b1; refDout = '0;

    vecs[0] = '{1, 0, 0, 32'h10, 32'h00, 32'h00, 32'hCAFE0001, 0, 0, 32'h10, 32'hCAFE0001};
    vecs[1] = '{0, 0, 1, 32'h00, 32'h20, 32'h55, 32'hDEAD0000, 1, 1, 32'h20, 32'hCAFE0001};
    vecs[2] = '{0, 1, 1, 32'h00, 32'h24, 32'h66, 32'hDEAD0001, 1, 1, 32'h24, 32'hCAFE0001};
    vecs[3] = '{1, 1, 0, 32'h30, 32'h34, 32'h00, 32'h11111111, 0, 0, 32'h30, 32'h11111111};
    vecs[4] = '{1, 1, 0, 32'h40, 32'h44, 32'h00, 32'h22222222, 1, 0, 32'h44, 32'h22222222};
    vecs[5] = '{0, 1, 0, 32'h00, 32'h50, 32'h00, 32'h33333333, 1, 0, 32'h50, 32'h33333333};
    vecs[6] = '{1, 0, 1, 32'h60, 32'h64, 32'h77, 32'h44444444, 0, 0, 32'h60, 32'h44444444};

    repeat (2) tick();
    check("rstGnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rstDone", {30'd0, done1, done0}, 32'd0);
    check("rstErr", {30'd0, err1, err0}, 32'd0);
    check("rstStrobe", {30'd0, memWr, memRd}, 32'd0);
    check("rstDataOut", dataOut, 32'd0);
    check("rstMemAddr", memAddr, 32'd0);
    rstN = 1'b1;

    foreach (vecs[i])
      doTxn(vecs[i].r0, vecs[i].r1rd, vecs[i].r1wr, vecs[i].a0, vecs[i].a1,
            vecs[i].wd, vecs[i].rdv, vecs[i].eOwn, vecs[i].eWr,
            vecs[i].eAddr, vecs[i].eDout, i % 3, (i == 5) ? 1 : 0);

    // ACK stuck high after capture with the request still held.
    begin
      int doneCount = 0;
      req0Rd = 1'b1; req0Addr = 32'h70;
      tick();
      check("recGrant", {31'd0, gnt0 & memRd}, 32'd1);
      memAck = 1'b1; memIn = 32'hBEEF0070;
      tick();
      doneCount += done0;
      check("recData", dataOut, 32'hBEEF0070);
      for (int i = 0; i < 3; i++) begin
        tick();
        doneCount += done0;
        check("recHold", {30'd0, memWr, memRd}, 32'd0);
      end
      memAck = 1'b0;
      tick();
      doneCount += done0;
      check("recIdle", {31'd0, memRd}, 32'd0);
      tick();
      check("recRegrant", {31'd0, gnt0 & memRd}, 32'd1);
      check("recOneDone", doneCount, 32'd1);
      req0Rd = 1'b0;
      memAck = 1'b1; memIn = 32'hBEEF0071;
      tick();
      memAck = 1'b0;
      tick();
      refLast = 1'b0; refDout = 32'hBEEF0071;
    end

    // Both ports held: grants must alternate.
    req0Rd = 1'b1; req1Wr = 1'b1;
    req0Addr = 32'h80; req1Addr = 32'h84; req1Data = 32'hA5A5A5A5;
    tick();
    for (int g = 0; g < 4; g++) begin
      int w = 0;
      bit eo;
      logic [31:0] rv;
      while (!(memRd || memWr) && w < 10) begin
        tick();
        w++;
      end
      check("altGrantSeen", {31'd0, memRd | memWr}, 32'd1);
      eo = !refLast;
      check("altOwner", {30'd0, gnt1, gnt0}, eo ? 32'd2 : 32'd1);
      check("altOp", {30'd0, memWr, memRd}, eo ? 32'd2 : 32'd1);
      check("altAddr", memAddr, eo ? 32'h84 : 32'h80);
      if (eo) check("altWData", memWData, 32'hA5A5A5A5);
      rv = $urandom;
      memAck = 1'b1; memIn = rv;
      tick();
      check("altDone", {30'd0, done1, done0}, eo ? 32'd2 : 32'd1);
      if (!eo) refDout = rv;
      check("altDataOut", dataOut, refDout);
      memAck = 1'b0;
      tick();
      refLast = eo;
    end
    req0Rd = 1'b0; req1Wr = 1'b0;
    tick();

    // Memory never acknowledges.
    req1Rd = 1'b1; req1Addr = 32'h90;
    tick();
    req1Rd = 1'b0;
    check("toGrant", {31'd0, gnt1 & memRd}, 32'd1);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      check("toStrobeHeld", {31'd0, memRd}, 32'd1);
    end
    tick();
    check("toStrobeDrop", {31'd0, memRd}, 32'd0);
    check("toDoneErr", {28'd0, done1, err1, done0, err0}, 32'b1100);
    check("toDataKept", dataOut, refDout);
    tick();
    check("toErrPulse", {30'd0, err1, err0}, 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("noToStrobeHeld", {31'd0, memRd}, 32'd1);
      check("noToErr", {30'd0, err1, err0}, 32'd0);
    end
    memAck = 1'b1; memIn = 32'h12345678;
    tick();
    check("noToDone", {29'd0, done1, err1, done0}, 32'b100);
    memAck = 1'b0;
    tick();
    refDout = 32'h12345678;
`endif
    refLast = 1'b1;

    // Reset in the middle of a read.
    req0Rd = 1'b1; req0Addr = 32'hA0;
    tick();
    req0Rd = 1'b0;
    check("midGrant", {31'd0, memRd}, 32'd1);
    #2 rstN = 1'b0;
    #1 check("midRstAsync", {30'd0, memRd, gnt0}, 32'd0);
    tick();
    check("midRstNoDone", {30'd0, done1, done0}, 32'd0);
    rstN = 1'b1;
    refLast = 1'b1; refDout = '0;
    doTxn(1, 1, 0, 32'hB0, 32'hB4, 32'h0, 32'h5A5A0000, predictOwner(1, 1), 0,
          32'hB0, 32'h5A5A0000, 0, 0);

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      bit r0, r1rd, r1wr, eo, ew;
      logic [31:0] a0, a1, wd, rv;
      r0 = 1'($urandom); r1rd = 1'($urandom); r1wr = 1'($urandom);
      if (!(r0 || r1rd || r1wr)) r0 = 1'b1;
      a0 = $urandom; a1 = $urandom; wd = $urandom; rv = $urandom;
      eo = predictOwner(r0, r1rd || r1wr);
      ew = eo && r1wr;
      doTxn(r0, r1rd, r1wr, a0, a1, wd, rv, eo, ew, eo ? a1 : a0,
            ew ? refDout : rv, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
